// File: rtl/fifo_out.sv
// fifo_out -- registered status and handshake flag decoder for an 8-entry FIFO.
//
// Sits between the FIFO control FSM and the FIFO ports. It decodes the
// controller state code and the occupancy count into flags. Every output is
// registered, so it shows the inputs sampled at the previous rising edge.
//
// Optional feature macro: FIFO_OUT_ALMOST_EN adds almost_full/almost_empty.
//
// Ports:
//   clk           system clock; outputs update on the rising edge
//   reset_n       asynchronous active-low reset
//   state         controller state code (3 bits)
//   data_count    number of stored entries (CNT_W bits)
//   full          data_count >= DEPTH
//   empty         data_count == 0
//   wr_ack        state is WRITE
//   wr_err        state is WR_ERROR
//   rd_ack        state is READ
//   rd_err        state is RD_ERROR
//   almost_full   data_count == DEPTH-1   (FIFO_OUT_ALMOST_EN only)
//   almost_empty  data_count == 1         (FIFO_OUT_ALMOST_EN only)
module fifo_out #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       state,
  input  logic [CNT_W-1:0] data_count,
  output logic             full,
  output logic             empty,
  output logic             wr_ack,
  output logic             wr_err,
  output logic             rd_ack,
  output logic             rd_err
`ifdef FIFO_OUT_ALMOST_EN
  ,
  output logic             almost_full,
  output logic             almost_empty
`endif
);

  // 011 and 100 are reserved codes; they fall into the default decode path
  // and behave exactly like INIT / NO_OP (no handshake flag raised).
  typedef enum logic [2:0] {
    ST_INIT     = 3'b000,
    ST_WRITE    = 3'b001,
    ST_READ     = 3'b010,
    ST_WR_ERROR = 3'b101,
    ST_RD_ERROR = 3'b110,
    ST_NO_OP    = 3'b111
  } state_e;

  localparam logic [CNT_W-1:0] L_DEPTH = CNT_W'(DEPTH);

  logic w_full;
  logic w_empty;
  logic w_wr_ack;
  logic w_wr_err;
  logic w_rd_ack;
  logic w_rd_err;

  logic r_full;
  logic r_empty;
  logic r_wr_ack;
  logic r_wr_err;
  logic r_rd_ack;
  logic r_rd_err;

  // Count flags ignore state; counts above DEPTH still read as full.
  always_comb begin
    w_full  = (data_count >= L_DEPTH);
    w_empty = (data_count == '0);
  end

  // Handshake flags are one-hot from state and deliberately not qualified by
  // the count: the controller has already decided accept/reject.
  always_comb begin
    w_wr_ack = 1'b0;
    w_wr_err = 1'b0;
    w_rd_ack = 1'b0;
    w_rd_err = 1'b0;
    case (state)
      ST_WRITE:    w_wr_ack = 1'b1;
      ST_READ:     w_rd_ack = 1'b1;
      ST_WR_ERROR: w_wr_err = 1'b1;
      ST_RD_ERROR: w_rd_err = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_wr_ack <= 1'b0;
      r_wr_err <= 1'b0;
      r_rd_ack <= 1'b0;
      r_rd_err <= 1'b0;
    end else begin
      r_full   <= w_full;
      r_empty  <= w_empty;
      r_wr_ack <= w_wr_ack;
      r_wr_err <= w_wr_err;
      r_rd_ack <= w_rd_ack;
      r_rd_err <= w_rd_err;
    end
  end

  assign full   = r_full;
  assign empty  = r_empty;
  assign wr_ack = r_wr_ack;
  assign wr_err = r_wr_err;
  assign rd_ack = r_rd_ack;
  assign rd_err = r_rd_err;

`ifdef FIFO_OUT_ALMOST_EN
  localparam logic [CNT_W-1:0] L_DEPTH_M1 = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] L_ONE      = CNT_W'(1);

  logic w_almost_full;
  logic w_almost_empty;
  logic r_almost_full;
  logic r_almost_empty;

  always_comb begin
    w_almost_full  = (data_count == L_DEPTH_M1);
    w_almost_empty = (data_count == L_ONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_almost_full  <= 1'b0;
      r_almost_empty <= 1'b0;
    end else begin
      r_almost_full  <= w_almost_full;
      r_almost_empty <= w_almost_empty;
    end
  end

  assign almost_full  = r_almost_full;
  assign almost_empty = r_almost_empty;
`endif

endmodule

// File: tb/tb_fifo_out.sv
module tb_fifo_out;

  logic       clk;
  logic       reset_n;
  logic [2:0] state;
  logic [3:0] data_count;
  logic       full, empty, wr_ack, wr_err, rd_ack, rd_err;
`ifdef FIFO_OUT_ALMOST_EN
  logic       almost_full, almost_empty;
`endif

  fifo_out #(.DEPTH(8), .CNT_W(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .state      (state),
    .data_count (data_count),
    .full       (full),
    .empty      (empty),
    .wr_ack     (wr_ack),
    .wr_err     (wr_err),
    .rd_ack     (rd_ack),
    .rd_err     (rd_err)
`ifdef FIFO_OUT_ALMOST_EN
    ,
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // expected flag vector ordering: {full, empty, wr_ack, wr_err, rd_ack, rd_err}
  localparam logic [5:0] RST_FLAGS = 6'b010000;

  typedef struct {
    logic [2:0] st;
    logic [3:0] cnt;
    logic [5:0] exp;
    logic [1:0] exp_alm;   // {almost_full, almost_empty}
  } vec_t;

  typedef struct {
    string      name;
    logic [5:0] exp;
    logic [1:0] exp_alm;
  } sb_t;

  vec_t vecs[18];
  sb_t  sb_q[$];

  function automatic logic [5:0] flags();
    return {full, empty, wr_ack, wr_err, rd_ack, rd_err};
  endfunction

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got flags=%b expected=%b (full,empty,wr_ack,wr_err,rd_ack,rd_err)",
               name, act, exp);
    end
  endtask

`ifdef FIFO_OUT_ALMOST_EN
  task automatic check_alm(input string name, input logic [1:0] exp);
    checks++;
    if ({almost_full, almost_empty} !== exp) begin
      failures++;
      $display("FAIL %s almost: got %b expected=%b (almost_full,almost_empty)",
               name, {almost_full, almost_empty}, exp);
    end
  endtask
`endif

  // Drive one vector between edges, queue its expectation, then compare
  // against the queue head once the registered outputs have updated.
  task automatic apply_vec(input int idx);
    sb_t e;
    @(negedge clk);
    state      = vecs[idx].st;
    data_count = vecs[idx].cnt;
    e.name    = $sformatf("vec%0d st=%b cnt=%0d", idx, vecs[idx].st, vecs[idx].cnt);
    e.exp     = vecs[idx].exp;
    e.exp_alm = vecs[idx].exp_alm;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard: queue empty at output, expected 1 entry");
    end else begin
      e = sb_q.pop_front();
      check(e.name, flags(), e.exp);
`ifdef FIFO_OUT_ALMOST_EN
      check_alm(e.name, e.exp_alm);
`endif
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{3'b000, 4'd0,  6'b010000, 2'b00};
    vecs[1]  = '{3'b111, 4'd0,  6'b010000, 2'b00};
    vecs[2]  = '{3'b011, 4'd0,  6'b010000, 2'b00};
    vecs[3]  = '{3'b100, 4'd0,  6'b010000, 2'b00};
    vecs[4]  = '{3'b001, 4'd0,  6'b011000, 2'b00};
    vecs[5]  = '{3'b001, 4'd8,  6'b101000, 2'b00};
    vecs[6]  = '{3'b101, 4'd8,  6'b100100, 2'b00};
    vecs[7]  = '{3'b110, 4'd0,  6'b010001, 2'b00};
    vecs[8]  = '{3'b010, 4'd4,  6'b000010, 2'b00};
    vecs[9]  = '{3'b010, 4'd15, 6'b100010, 2'b00};
    vecs[10] = '{3'b111, 4'd7,  6'b000000, 2'b10};
    vecs[11] = '{3'b111, 4'd1,  6'b000000, 2'b01};
    vecs[12] = '{3'b000, 4'd4,  6'b000000, 2'b00};
    vecs[13] = '{3'b001, 4'd9,  6'b101000, 2'b00};
    vecs[14] = '{3'b011, 4'd8,  6'b100000, 2'b00};
    vecs[15] = '{3'b100, 4'd15, 6'b100000, 2'b00};
    vecs[16] = '{3'b110, 4'd1,  6'b000001, 2'b01};
    vecs[17] = '{3'b101, 4'd7,  6'b000100, 2'b10};

    // Reset held across edges with active-looking inputs: outputs stay at reset values.
    reset_n    = 1'b0;
    state      = 3'b001;
    data_count = 4'd8;
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", flags(), RST_FLAGS);
`ifdef FIFO_OUT_ALMOST_EN
    check_alm("reset_hold", 2'b00);
`endif

    // Release between edges: no change until the next rising edge.
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("release_before_edge", flags(), RST_FLAGS);
    @(posedge clk);
    #1;
    check("first_edge_after_release", flags(), 6'b101000);

    for (int i = 0; i < 18; i++) apply_vec(i);

    // Mid-operation asynchronous reset: outputs drop without a clock edge.
    @(negedge clk);
    state      = 3'b010;
    data_count = 4'd15;
    @(posedge clk);
    #1;
    check("pre_async_reset", flags(), 6'b100010);
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("async_reset_immediate", flags(), RST_FLAGS);
`ifdef FIFO_OUT_ALMOST_EN
    check_alm("async_reset_immediate", 2'b00);
`endif
    @(posedge clk);
    #1;
    check("async_reset_held", flags(), RST_FLAGS);

    @(negedge clk);
    reset_n    = 1'b1;
    state      = 3'b110;
    data_count = 4'd0;
    @(posedge clk);
    #1;
    check("recover_after_reset", flags(), 6'b010001);

    if (sb_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
